// File: rtl/priority_enc_pkg.sv
// rtl/priority_enc_pkg.sv - shared width default and MSB-relative index helper
package priority_enc_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam int MAX_WIDTH     = 64;

  // Index of the highest set bit counted from the MSB; 0 when no bit is set.
  function automatic int msb_index(input logic [MAX_WIDTH-1:0] d, input int width);
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      if (i < width && d[i]) idx = (width - 1) - i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/priority_enc_comb.sv
// rtl/priority_enc_comb.sv - combinational MSB-first priority encoder
module priority_enc_comb
  import priority_enc_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  localparam int YW = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] d,
  output logic [YW-1:0]    y_next,
  output logic             valid_next
);

  // Ascending scan so the highest set index is the last assignment to stick.
  always_comb begin
    y_next     = '0;
    valid_next = |d;
    for (int i = 0; i < WIDTH; i++) begin
      if (d[i]) y_next = YW'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/priority_enc.sv
// rtl/priority_enc.sv - registered priority encoder top
module priority_enc
  import priority_enc_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  localparam int YW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] D,
  output logic [YW-1:0]    Y,
  output logic             valid
);

  logic [YW-1:0] y_next;
  logic          valid_next;

  priority_enc_comb #(.WIDTH(WIDTH)) u_comb (
    .d          (D),
    .y_next     (y_next),
    .valid_next (valid_next)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      Y     <= '0;
      valid <= 1'b0;
    end else begin
      Y     <= y_next;
      valid <= valid_next;
    end
  end

endmodule

// File: tb/tb_priority_enc.sv
// tb/tb_priority_enc.sv - directed self-checking bench for priority_enc
module tb_priority_enc;
  import priority_enc_pkg::*;

  logic       clk;
  logic       rst;
  logic [3:0] D;
  logic [1:0] Y;
  logic       valid;

  int n_cmp = 0;
  int n_err = 0;

  priority_enc #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .D     (D),
    .Y     (Y),
    .valid (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [3:0] d);
    D = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_out(input string tag, input int ey, input logic ev);
    chk({tag, "_y"}, {30'd0, Y}, ey);
    chk({tag, "_valid"}, {31'd0, valid}, {31'd0, ev});
  endtask

  logic [3:0] oh_d [5] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0000};
  int         oh_y [5] = '{0, 1, 2, 3, 0};
  logic       oh_v [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [3:0] mb_d [4] = '{4'b1111, 4'b0110, 4'b0011, 4'b1001};
  int         mb_y [4] = '{0, 1, 2, 0};

  initial begin
    rst = 1'b0;
    D   = 4'b1111;

    step(4'b1111);
    chk_out("reset_edge1", 0, 1'b0);
    step(4'b1111);
    chk_out("reset_edge2", 0, 1'b0);
    rst = 1'b1;

    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < 5; i++) begin
        step(oh_d[i]);
        chk_out($sformatf("onehot_%0d_%b", r, oh_d[i]), oh_y[i], oh_v[i]);
      end
    end

    for (int i = 0; i < 4; i++) begin
      step(mb_d[i]);
      chk_out($sformatf("multi_%b", mb_d[i]), mb_y[i], 1'b1);
    end

    step(4'b0001);
    chk_out("lat_pre", 3, 1'b1);
    D = 4'b1000;
    #2;
    chk_out("lat_mid", 3, 1'b1);
    @(posedge clk);
    #1;
    chk_out("lat_post", 0, 1'b1);
    @(negedge clk);

    step(4'b0100);
    chk_out("midrst_before", 1, 1'b1);
    rst = 1'b0;
    step(4'b0100);
    chk_out("midrst_during", 0, 1'b0);
    rst = 1'b1;
    step(4'b0100);
    chk_out("midrst_after", 1, 1'b1);

    for (int v = 0; v < 16; v++) begin
      logic [63:0] dv;
      dv = 64'(v);
      step(4'(v));
      chk_out($sformatf("exh_%b", 4'(v)), msb_index(dv, 4), (v != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
